sync_fifo_ext: RTL and testbench

Parametrised second-generation synchronous FIFO for the OpenDVS event path. It buffers DWIDTH-bit event words in a power-of-two circular buffer. Over the first-generation FIFO it adds:
- selectable read mode (show-ahead or registered output);
- almost-full / almost-empty thresholds;
- pass-through write when full;
- sticky overflow/underflow flags;
- a high-water-mark monitor;
- a synchronous flush.

It sits between the event arbiter and the readout/serialiser and is the standard buffer for new event-path blocks.

---
 rtl/sync_fifo_ext.sv | 147 ++++++++++++++
 tb/tb_sync_fifo_ext.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ext.sv
// Synchronous event-path FIFO: power-of-two circular buffer with show-ahead or
// registered read, occupancy thresholds, sticky error flags, high-water mark and flush.
module sync_fifo_ext #(
    parameter int DWIDTH        = 136,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int READ_MODE     = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DWIDTH-1:0]      wdata,
    input  logic                   rd_en,
    output logic [DWIDTH-1:0]      rdata,
    output logic                   rvalid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] numel,
    output logic [$clog2(DEPTH):0] hwm,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_N  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_N  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_N = CW'(AEMPTY_THRESH);

    if (DWIDTH < 1) begin : g_bad_dwidth
        $fatal(1, "sync_fifo_ext: DWIDTH must be >= 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo_ext: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $fatal(1, "sync_fifo_ext: AFULL_THRESH out of range 1..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
        $fatal(1, "sync_fifo_ext: AEMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     numel_q;
    logic [CW-1:0]     numel_nxt;
    logic [CW-1:0]     hwm_q;
    logic              ovf_q;
    logic              udf_q;
    logic              rd_acc;
    logic              wr_acc;

    assign empty        = (numel_q == '0);
    assign full         = (numel_q == DEPTH_N);
    assign almost_empty = (numel_q <= AEMPTY_N);
    assign almost_full  = (numel_q >= AFULL_N);
    assign numel        = numel_q;
    assign hwm          = hwm_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A write into a full FIFO only fits if a read frees the head slot this cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        numel_nxt = numel_q;
        if (wr_acc && !rd_acc) begin
            numel_nxt = numel_q + CW'(1);
        end else if (!wr_acc && rd_acc) begin
            numel_nxt = numel_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            numel_q <= '0;
            hwm_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            numel_q <= '0;
            hwm_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            numel_q <= numel_nxt;
            if (numel_nxt > hwm_q) begin
                hwm_q <= numel_nxt;
            end
            if (wr_en && !wr_acc) begin
                ovf_q <= 1'b1;
            end
            if (rd_en && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    if (READ_MODE == 0) begin : g_show_ahead
        assign rdata  = mem[rd_ptr];
        assign rvalid = !empty;
    end else begin : g_registered
        logic [DWIDTH-1:0] rdata_p1;
        logic              vld_p1;

        // Stage p1: word captured on the edge that accepts the read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_p1 <= '0;
                vld_p1   <= 1'b0;
            end else if (flush) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= rd_acc;
                if (rd_acc) begin
                    rdata_p1 <= mem[rd_ptr];
                end
            end
        end

        assign rdata  = rdata_p1;
        assign rvalid = vld_p1;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: show-ahead and registered instances share one stimulus
// stream and are compared every cycle against a queue-based reference.
module tb_sync_fifo_ext;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          rd_en = 1'b0;

    logic [DW-1:0] rdata0, rdata1;
    logic          rvalid0, rvalid1;
    logic          empty0, full0, aempty0, afull0, ovf0, udf0;
    logic          empty1, full1, aempty1, afull1, ovf1, udf1;
    logic [2:0]    numel0, hwm0, numel1, hwm1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DWIDTH(DW), .DEPTH(DP), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .READ_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata0), .rvalid(rvalid0), .empty(empty0), .full(full0),
        .almost_empty(aempty0), .almost_full(afull0), .numel(numel0), .hwm(hwm0),
        .overflow(ovf0), .underflow(udf0));

    sync_fifo_ext #(.DWIDTH(DW), .DEPTH(DP), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .READ_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata1), .rvalid(rvalid1), .empty(empty1), .full(full1),
        .almost_empty(aempty1), .almost_full(afull1), .numel(numel1), .hwm(hwm1),
        .overflow(ovf1), .underflow(udf1));

    // Reference: FIFO contents as a queue, plus the monitor/flag state.
    logic [DW-1:0] q[$];
    int            m_hwm = 0;
    bit            m_ovf = 0;
    bit            m_udf = 0;
    logic [DW-1:0] m_rd1 = '0;
    bit            m_rv1 = 0;

    always @(posedge clk or negedge rst_n) begin
        bit racc, wacc;
        if (!rst_n) begin
            q.delete();
            m_hwm = 0; m_ovf = 0; m_udf = 0; m_rd1 = '0; m_rv1 = 0;
        end else if (flush) begin
            q.delete();
            m_hwm = 0; m_ovf = 0; m_udf = 0; m_rv1 = 0;
        end else begin
            racc = rd_en && (q.size() > 0);
            wacc = wr_en && ((q.size() < DP) || racc);
            if (rd_en && q.size() == 0) m_udf = 1;
            if (wr_en && !wacc) m_ovf = 1;
            m_rv1 = racc;
            if (racc) m_rd1 = q.pop_front();
            if (wacc) q.push_back(wdata);
            if (q.size() > m_hwm) m_hwm = q.size();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int n;
        if (rst_n) begin
            n = q.size();
            chk("numel0", 32'(numel0), 32'(n));
            chk("numel1", 32'(numel1), 32'(n));
            chk("empty0", 32'(empty0), 32'(n == 0));
            chk("empty1", 32'(empty1), 32'(n == 0));
            chk("full0", 32'(full0), 32'(n == DP));
            chk("full1", 32'(full1), 32'(n == DP));
            chk("aempty0", 32'(aempty0), 32'(n <= 1));
            chk("aempty1", 32'(aempty1), 32'(n <= 1));
            chk("afull0", 32'(afull0), 32'(n >= 3));
            chk("afull1", 32'(afull1), 32'(n >= 3));
            chk("hwm0", 32'(hwm0), 32'(m_hwm));
            chk("hwm1", 32'(hwm1), 32'(m_hwm));
            chk("ovf0", 32'(ovf0), 32'(m_ovf));
            chk("ovf1", 32'(ovf1), 32'(m_ovf));
            chk("udf0", 32'(udf0), 32'(m_udf));
            chk("udf1", 32'(udf1), 32'(m_udf));
            chk("rvalid0", 32'(rvalid0), 32'(n != 0));
            if (n != 0) chk("rdata0", 32'(rdata0), 32'(q[0]));
            chk("rvalid1", 32'(rvalid1), 32'(m_rv1));
            chk("rdata1", 32'(rdata1), 32'(m_rd1));
        end
    end

    // One clock of stimulus; returns just after the edge so post-edge state can be checked.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        @(negedge clk);
        wr_en = w; wdata = d; rd_en = r; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int mode;
        #12;
        chk("rst_numel", 32'(numel0), 32'd0);
        chk("rst_empty", 32'(empty1), 32'd1);
        chk("rst_rdata1", 32'(rdata1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full
        cyc(1, 8'h11, 0, 0); chk("t1_n1", 32'(numel0), 32'd1); chk("t1_ae1", 32'(aempty0), 32'd1);
        cyc(1, 8'h22, 0, 0); chk("t1_ae2", 32'(aempty0), 32'd0);
        cyc(1, 8'h33, 0, 0); chk("t1_af3", 32'(afull0), 32'd1); chk("t1_full3", 32'(full0), 32'd0);
        cyc(1, 8'h44, 0, 0); chk("t1_full4", 32'(full0), 32'd1); chk("t1_hwm", 32'(hwm0), 32'd4);
        chk("t1_rdata0", 32'(rdata0), 32'h11); chk("t1_rvalid0", 32'(rvalid0), 32'd1);

        // Overflow, then pass-through, then drain
        cyc(1, 8'h55, 0, 0); chk("t2_ovf", 32'(ovf0), 32'd1); chk("t2_numel", 32'(numel0), 32'd4);
        cyc(1, 8'h66, 1, 0); chk("t2_pt_rd", 32'(rdata1), 32'h11); chk("t2_pt_n", 32'(numel1), 32'd4);
        cyc(0, 8'h00, 1, 0); chk("t2_d1", 32'(rdata1), 32'h22);
        cyc(0, 8'h00, 1, 0); chk("t2_d2", 32'(rdata1), 32'h33);
        cyc(0, 8'h00, 1, 0); chk("t2_d3", 32'(rdata1), 32'h44);
        cyc(0, 8'h00, 1, 0); chk("t2_d4", 32'(rdata1), 32'h66); chk("t2_empty", 32'(empty0), 32'd1);

        // Write+read on empty
        cyc(1, 8'hA5, 1, 0); chk("t3_udf", 32'(udf0), 32'd1); chk("t3_n", 32'(numel0), 32'd1);
        chk("t3_rd0", 32'(rdata0), 32'hA5);
        cyc(0, 8'h00, 1, 0); chk("t3_rd1", 32'(rdata1), 32'hA5);

        // Registered read latency
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0); chk("t4_rv_pre", 32'(rvalid1), 32'd0);
        cyc(0, 8'h00, 1, 0); chk("t4_rv1", 32'(rvalid1), 32'd1); chk("t4_rd1", 32'(rdata1), 32'h01);
        cyc(0, 8'h00, 1, 0); chk("t4_rv2", 32'(rvalid1), 32'd1); chk("t4_rd2", 32'(rdata1), 32'h02);
        cyc(0, 8'h00, 0, 0); chk("t4_rv3", 32'(rvalid1), 32'd0); chk("t4_hold", 32'(rdata1), 32'h02);

        // Steady state at occupancy 2, pointers wrap
        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'hB0, 0, 0);
        cyc(1, 8'hB1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 8'(8'hC0 + i), 1, 0);
            chk("t5_order", 32'(rdata1), (i < 2) ? 32'(8'hB0 + i) : 32'(8'hC0 + i - 2));
        end
        chk("t5_hwm", 32'(hwm0), 32'd2); chk("t5_n", 32'(numel0), 32'd2);

        // Flush clears monitor state and ignores the concurrent write
        cyc(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t6_pre_ovf", 32'(ovf0), 32'd1); chk("t6_pre_n", 32'(numel0), 32'd3);
        chk("t6_pre_hwm", 32'(hwm0), 32'd4);
        cyc(1, 8'h77, 0, 1);
        chk("t6_n", 32'(numel0), 32'd0); chk("t6_hwm", 32'(hwm1), 32'd0);
        chk("t6_ovf", 32'(ovf1), 32'd0); chk("t6_empty", 32'(empty0), 32'd1);
        chk("t6_rdhold", 32'(rdata1), 32'h10); chk("t6_rv", 32'(rvalid1), 32'd0);

        // Randomised traffic in write-heavy, read-heavy and balanced phases
        for (int i = 0; i < 3000; i++) begin
            mode = i / 500;
            case (mode % 3)
                0: cyc($urandom_range(0, 9) < 8, 8'($urandom), $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
                1: cyc($urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 9) < 8, $urandom_range(0, 99) == 0);
                default: cyc($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
            endcase
        end

        // Asynchronous reset mid-stream
        cyc(1, 8'h99, 0, 0);
        cyc(1, 8'h9A, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_numel", 32'(numel0), 32'd0); chk("ar_hwm", 32'(hwm1), 32'd0);
        chk("ar_empty", 32'(empty0), 32'd1); chk("ar_ovf", 32'(ovf0), 32'd0);
        chk("ar_udf", 32'(udf1), 32'd0); chk("ar_rv1", 32'(rvalid1), 32'd0);
        chk("ar_rd1", 32'(rdata1), 32'd0); chk("ar_rv0", 32'(rvalid0), 32'd0);
        @(negedge clk);
        wr_en = 0; rd_en = 0; flush = 0;
        rst_n = 1'b1;
        cyc(1, 8'h3C, 0, 0); chk("ar_post", 32'(rdata0), 32'h3C);
        cyc(0, 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
